keypad_scanner: RTL
===================

# keypad_scanner

Scans the 4x4 matrix keypad by driving one column low at a time and sampling the rows. It debounces each press and emits the 4-bit key code consumed by the seven-segment decoder (`seg7_control`). The block sits between the keypad pins and the display path, and is the producer of the `dec` code that the decoder interprets.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per column step; must be ≥ 4.
- `DEBOUNCE_CNT`, default 20: consecutive agreeing scan samples required to accept a press or a release; must be ≥ 2.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `row_i`  in  4  keypad rows; active-low, pulled up, asynchronous to `clk`.
- `col_o`  out  4  column drive; active-low one-hot.
- `key_code`  out  4  code of the last accepted key; held until the next accepted press.
- `key_valid`  out  1  one-cycle pulse when a new press is accepted.
- `key_held`  out  1  high while the accepted key remains pressed, up to the end of release debounce.

## Operation
- **Key code format:** `key_code = {row_idx[1:0], 2'd3 - col_idx[1:0]}`.
  - Rows 0..3 are top to bottom: `1 2 3 A`, `4 5 6 B`, `7 8 9 C`, `* 0 # D`.
  - Column 0 is leftmost.
  - Examples: 1=0011, A=0000, 5=0110, 0=1110, #=1101.
- **Row synchronizer:** `row_i` passes through a 2-flop synchronizer; all decisions use the synchronized value `row_s`.
- **Scan tick:** the divider counts 0..SCAN_DIV-1 and asserts `tick` in the cycle where it equals SCAN_DIV-1, then wraps to 0. It free-runs in every state.
- **State SCAN:**
  - On `tick` with `row_s == 4'b1111`: advance `col_idx` (3 wraps to 0).
  - On `tick` with any row low: latch `col_idx` and `row_idx`. The lowest-index low row wins. Set `stable_cnt = 1` and go to DEBOUNCE. The column does not advance.
- **State DEBOUNCE (column frozen):**
  - On `tick` with the latched row still low: if `stable_cnt == DEBOUNCE_CNT-1`, go to PRESSED, load `key_code`, and pulse `key_valid`. Otherwise increment `stable_cnt`.
  - On `tick` with the latched row high: go to SCAN, advance the column, no output change.
- **State PRESSED (column frozen, `key_held` = 1):**
  - On `tick` with the latched row high: increment `rel_cnt`. When `rel_cnt` reaches DEBOUNCE_CNT, go to SCAN, advance the column, and clear `key_held`.
  - On `tick` with the latched row low: clear `rel_cnt`.
- **Ignored inputs:** other rows and other columns are ignored while in DEBOUNCE or PRESSED. A held key produces exactly one `key_valid`; there is no auto-repeat.
- **Column drive:** `col_o = ~(4'b0001 << col_idx)`, registered.
- **Counter widths:** `$clog2(SCAN_DIV)` for the divider; `$clog2(DEBOUNCE_CNT+1)` for `stable_cnt` and `rel_cnt`. No counter may overflow.

## Timing
- **Reset values** (applied in the cycle after a `clk` edge with `rst_n = 0`):
  - `col_o` = 4'b1110, `key_code` = 4'b0000, `key_valid` = 0, `key_held` = 0.
  - State SCAN, `col_idx` = 0, all counters 0.
- **Settling:** `col_o` changes in the cycle after `tick`. Rows are sampled SCAN_DIV cycles later, which exceeds the 2-cycle synchronizer latency.
- **Press latency:** `key_valid`, the new `key_code` and `key_held = 1` appear together in the cycle after the tick that provides the DEBOUNCE_CNT-th consecutive low sample. The first low sample, taken in SCAN, counts as sample 1.
- **Release latency:** `key_held` falls in the cycle after the tick providing the DEBOUNCE_CNT-th consecutive high sample. The next column is driven in that same cycle.
- **Reset mid-operation:** reset in any state aborts it. No `key_valid` is emitted and all outputs take their reset values.
- **Pulse spacing:** `key_valid` is never high for two consecutive cycles. The minimum spacing between pulses is `2*DEBOUNCE_CNT*SCAN_DIV` cycles.

## Structure
- **Package `keypad_pkg`:**
  - State enum `scan_state_t` with values SCAN, DEBOUNCE, PRESSED.
  - Key code constants KEY_0..KEY_9, KEY_A..KEY_D, KEY_STAR, KEY_HASH.
  - Function `key_code_f(row_idx, col_idx)`.
- **Sub-module `sync_2ff`:** a 4-bit-wide 2-flop synchronizer with reset value 4'b1111.
- **Top-level logic:** divider, FSM, counters and output registers live in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CNT=3. The keypad model pulls `row_i[r]` low whenever key (r,c) is pressed and `col_o[c] == 0`.
- **Reset:** `rst_n` low for 3 cycles, then high -> `col_o` = 1110, `key_code` = 0000, `key_valid` = 0, `key_held` = 0. `col_o` then steps 1101, 1011, 0111, 1110, one step every 4 cycles.
- **Single press:** press "5" (row 1, col 1) for 40 cycles, then release -> one `key_valid` pulse, `key_code` = 0110, `key_held` = 1 until 3 high samples after release. Scanning then resumes at column 2.
- **Bounce rejection:** "9" (row 2, col 2) low for exactly one sample, then high -> no `key_valid`, `key_code` unchanged, state returns to SCAN.
- **Long hold and re-press:** hold "#" for 200 cycles, release, then press again -> exactly two `key_valid` pulses, both with `key_code` = 1101.
- **Multi-key priority:** "1" and "4" pressed together (rows 0 and 1, col 0) -> `key_code` = 0011, single pulse.
- **Reset in DEBOUNCE:** press "D" and assert `rst_n` = 0 while in DEBOUNCE -> no `key_valid`, reset values observed in the next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key-code constants and helpers for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } scan_state_t;

  // Code = {row, 3 - col}; rows top to bottom, column 0 leftmost.
  localparam logic [3:0] KEY_A    = 4'b0000;
  localparam logic [3:0] KEY_3    = 4'b0001;
  localparam logic [3:0] KEY_2    = 4'b0010;
  localparam logic [3:0] KEY_1    = 4'b0011;
  localparam logic [3:0] KEY_B    = 4'b0100;
  localparam logic [3:0] KEY_6    = 4'b0101;
  localparam logic [3:0] KEY_5    = 4'b0110;
  localparam logic [3:0] KEY_4    = 4'b0111;
  localparam logic [3:0] KEY_C    = 4'b1000;
  localparam logic [3:0] KEY_9    = 4'b1001;
  localparam logic [3:0] KEY_8    = 4'b1010;
  localparam logic [3:0] KEY_7    = 4'b1011;
  localparam logic [3:0] KEY_D    = 4'b1100;
  localparam logic [3:0] KEY_HASH = 4'b1101;
  localparam logic [3:0] KEY_0    = 4'b1110;
  localparam logic [3:0] KEY_STAR = 4'b1111;

  function automatic logic [3:0] key_code_f(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
    return {row_idx, 2'd3 - col_idx};
  endfunction

  // Lowest-index active-low row wins when several rows are pulled down.
  function automatic logic [1:0] low_row_f(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    if (!rows[2]) idx = 2'd2;
    if (!rows[1]) idx = 2'd1;
    if (!rows[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Four-bit two-flop synchronizer; resets to all-high to match idle keypad rows.
module sync_2ff (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks an active-low column, debounces press and release of one key,
// and reports its code with a single-cycle valid pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CNT - 1);

  logic [3:0]      row_s;
  logic [DivW-1:0] div_q, div_d;
  logic            tick;

  scan_state_t     state_q, state_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [CntW-1:0] stable_cnt_q, stable_cnt_d;
  logic [CntW-1:0] rel_cnt_q, rel_cnt_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q;
  logic            accept;
  logic [3:0]      col_q;

  sync_2ff u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_i),
    .q     (row_s)
  );

  // Free-running divider; rows are only ever looked at on tick.
  assign tick  = (div_q == DivLast);
  assign div_d = tick ? '0 : div_q + DivW'(1);

  always_comb begin
    state_d      = state_q;
    col_idx_d    = col_idx_q;
    row_idx_d    = row_idx_q;
    stable_cnt_d = stable_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    key_code_d   = key_code_q;
    accept       = 1'b0;

    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (row_s == 4'b1111) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d    = low_row_f(row_s);
            stable_cnt_d = CntW'(1);
            state_d      = DEBOUNCE;
          end
        end

        DEBOUNCE: begin
          if (!row_s[row_idx_q]) begin
            if (stable_cnt_q == CntLast) begin
              state_d      = PRESSED;
              key_code_d   = key_code_f(row_idx_q, col_idx_q);
              accept       = 1'b1;
              stable_cnt_d = '0;
              rel_cnt_d    = '0;
            end else begin
              stable_cnt_d = stable_cnt_q + CntW'(1);
            end
          end else begin
            // Bounce: give up on this key and move on as if the column were idle.
            state_d      = SCAN;
            col_idx_d    = col_idx_q + 2'd1;
            stable_cnt_d = '0;
          end
        end

        PRESSED: begin
          if (row_s[row_idx_q]) begin
            if (rel_cnt_q == CntLast) begin
              state_d   = SCAN;
              col_idx_d = col_idx_q + 2'd1;
              rel_cnt_d = '0;
            end else begin
              rel_cnt_d = rel_cnt_q + CntW'(1);
            end
          end else begin
            rel_cnt_d = '0;
          end
        end

        default: begin
          state_d = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q        <= '0;
      state_q      <= SCAN;
      col_idx_q    <= 2'd0;
      row_idx_q    <= 2'd0;
      stable_cnt_q <= '0;
      rel_cnt_q    <= '0;
      key_code_q   <= 4'b0000;
      key_valid_q  <= 1'b0;
      col_q        <= 4'b1110;
    end else begin
      div_q        <= div_d;
      state_q      <= state_d;
      col_idx_q    <= col_idx_d;
      row_idx_q    <= row_idx_d;
      stable_cnt_q <= stable_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= accept;
      col_q        <= ~(4'b0001 << col_idx_d);
    end
  end

  assign col_o     = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == PRESSED);

endmodule
